sram_write_driver: RTL and testbench

- Write-path counterpart of the column sense amplifier: the sense amp reads the array, this block writes it.
- Accepts a write request (row address, column data, column mask) over a valid/ready handshake.
- Converts the request to real-valued analog drive on the array: per-row write wordlines plus per-column BL/BLB.
- Sequences the write as precharge, then drive, then recover. Sits between the digital controller and the memory-array model.

---
 rtl/sram_write_driver.sv | 149 ++++++++++++++
 tb/tb_sram_write_driver.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_write_driver.sv
// SRAM write driver: turns a digital write request into precharge / drive /
// recover analog levels on the write wordlines and the column bitline pairs.

// Per-column bitline driver: maps the registered column levels to rail voltages.
module sram_wr_col (
  input  logic bl_hi,
  input  logic blb_hi,
  output real  bl,
  output real  blb
);
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;

  assign bl  = bl_hi  ? VDD : VSS;
  assign blb = blb_hi ? VDD : VSS;
endmodule

module sram_write_driver #(
  parameter int ROWS       = 16,
  parameter int COLS       = 8,
  parameter int PRE_CYCLES = 2,
  parameter int WR_CYCLES  = 3,
  localparam int AW        = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [COLS-1:0] wr_data,
  input  logic [COLS-1:0] wr_mask,
  output logic            wr_done,
  output logic            wr_err,
  output logic            busy,
  output real             row_wr [0:ROWS-1],
  output real             bl_wr  [0:COLS-1],
  output real             blb_wr [0:COLS-1]
);
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam int  MAXC = (PRE_CYCLES > WR_CYCLES) ? PRE_CYCLES : WR_CYCLES;
  localparam int  CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {IDLE, PRE, DRIVE, RECOVER} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            accept, addr_ok, cap;
  logic            done_nx, err_nx;
  logic [AW-1:0]   addr_q;
  logic [COLS-1:0] data_q, mask_q;

  // Analog levels are held as single-bit registers (1 = VDD) so every real
  // output is exactly one rail and changes only on a clock edge.
  logic [ROWS-1:0] row_q, row_nx;
  logic [COLS-1:0] bl_q, bl_nx, blb_q, blb_nx;

  assign accept   = wr_valid & wr_ready;
  // Only meaningful for non-power-of-2 ROWS; otherwise always true.
  assign addr_ok  = ({1'b0, wr_addr} < (AW+1)'(ROWS));
  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Next-state, phase counter and next analog levels.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap      = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        if (addr_ok) begin
          state_nx = PRE;
          cnt_nx   = CW'(PRE_CYCLES - 1);
          cap      = 1'b1;
        end else begin
          err_nx = 1'b1;
        end
      end
      PRE: if (cnt == '0) begin
        state_nx = DRIVE;
        cnt_nx   = CW'(WR_CYCLES - 1);
      end else begin
        cnt_nx = cnt - 1'b1;
      end
      DRIVE: if (cnt == '0) state_nx = RECOVER;
             else           cnt_nx   = cnt - 1'b1;
      RECOVER: begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    // Precharged condition everywhere except during DRIVE; masked columns
    // keep both lines high so the cell is left untouched.
    row_nx = '0;
    bl_nx  = '1;
    blb_nx = '1;
    if (state_nx == DRIVE) begin
      for (int r = 0; r < ROWS; r++) row_nx[r] = (addr_q == AW'(r));
      bl_nx  =  data_q | ~mask_q;
      blb_nx = ~data_q | ~mask_q;
    end
  end

  // State, request capture and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
      row_q   <= '0;
      bl_q    <= '1;
      blb_q   <= '1;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      wr_done <= done_nx;
      wr_err  <= err_nx;
      row_q   <= row_nx;
      bl_q    <= bl_nx;
      blb_q   <= blb_nx;
      if (cap) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
        mask_q <= wr_mask;
      end
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign row_wr[r] = row_q[r] ? VDD : VSS;
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    sram_wr_col u_col (
      .bl_hi (bl_q[c]),
      .blb_hi(blb_q[c]),
      .bl    (bl_wr[c]),
      .blb   (blb_wr[c])
    );
  end
endmodule

// File: tb/tb_sram_write_driver.sv
// Directed bench for sram_write_driver: default instance plus a ROWS=12
// instance for the out-of-range address path.
module tb_sram_write_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default-parameter instance
  logic       wr_valid = 1'b0, wr_ready, wr_done, wr_err, busy;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0, wr_mask = '0;
  real        row_wr [0:15];
  real        bl_wr  [0:7];
  real        blb_wr [0:7];

  sram_write_driver u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .wr_done(wr_done), .wr_err(wr_err), .busy(busy),
    .row_wr(row_wr), .bl_wr(bl_wr), .blb_wr(blb_wr)
  );

  // ROWS=12 instance
  logic       v2 = 1'b0, rdy2, done2, err2, busy2;
  logic [3:0] a2 = '0;
  logic [7:0] d2 = '0, m2 = '0;
  real        row2 [0:11];
  real        bl2  [0:7];
  real        blb2 [0:7];

  sram_write_driver #(.ROWS(12)) u_dut12 (
    .clk(clk), .rst(rst), .wr_valid(v2), .wr_ready(rdy2),
    .wr_addr(a2), .wr_data(d2), .wr_mask(m2),
    .wr_done(done2), .wr_err(err2), .busy(busy2),
    .row_wr(row2), .bl_wr(bl2), .blb_wr(blb2)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_r(input string tag, input real obs, input real exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%f expected=%f", tag, obs, exp);
    end
  endtask

  // Analog state of the default instance: row = -1 means no wordline high;
  // bl/blb bit = 1 means that line is at 1.5 V.
  task automatic chk_ana(input string tag, input int row, input logic [7:0] bl, input logic [7:0] blb);
    for (int r = 0; r < 16; r++)
      chk_r($sformatf("%s row_wr[%0d]", tag, r), row_wr[r], (r == row) ? 1.5 : 0.0);
    for (int c = 0; c < 8; c++) begin
      chk_r($sformatf("%s bl_wr[%0d]", tag, c),  bl_wr[c],  bl[c]  ? 1.5 : 0.0);
      chk_r($sformatf("%s blb_wr[%0d]", tag, c), blb_wr[c], blb[c] ? 1.5 : 0.0);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic rdy, input logic dn, input logic er, input logic bz);
    chk_b({tag, " wr_ready"}, 32'(wr_ready), 32'(rdy));
    chk_b({tag, " wr_done"},  32'(wr_done),  32'(dn));
    chk_b({tag, " wr_err"},   32'(wr_err),   32'(er));
    chk_b({tag, " busy"},     32'(busy),     32'(bz));
  endtask

  initial begin
    real sa [0:7];

    // Reset
    tick(2);
    chk_ctl("reset", 1, 0, 0, 0);
    chk_ana("reset", -1, 8'hFF, 8'hFF);
    rst = 1'b0;
    tick();

    // Single write addr=5 data=A5 mask=FF; inputs scrambled after accept
    wr_valid = 1; wr_addr = 4'd5; wr_data = 8'hA5; wr_mask = 8'hFF;
    tick();                                     // accept edge
    wr_valid = 0; wr_addr = 4'd9; wr_data = 8'h00; wr_mask = 8'h00;
    chk_ctl("w1 pre0", 0, 0, 0, 1);
    chk_ana("w1 pre0", -1, 8'hFF, 8'hFF);
    tick();
    chk_ana("w1 pre1", -1, 8'hFF, 8'hFF);
    tick();
    chk_ana("w1 drv0", 5, 8'hA5, 8'h5A);
    tick();
    chk_ana("w1 drv1", 5, 8'hA5, 8'h5A);
    tick();
    chk_ana("w1 drv2", 5, 8'hA5, 8'h5A);
    chk_b("w1 done early", 32'(wr_done), 0);
    tick();
    chk_ctl("w1 recover", 0, 0, 0, 1);
    chk_ana("w1 recover", -1, 8'hFF, 8'hFF);
    tick();
    chk_ctl("w1 done", 1, 1, 0, 0);
    tick();
    chk_ctl("w1 after", 1, 0, 0, 0);

    // Masked write: only columns 0..3 driven
    wr_valid = 1; wr_addr = 4'd7; wr_data = 8'hFF; wr_mask = 8'h0F;
    tick();
    wr_valid = 0;
    tick(2);
    chk_ana("mask drv", 7, 8'hFF, 8'hF0);
    tick(4);
    chk_b("mask done", 32'(wr_done), 1);

    // Back-to-back: second request held pending until first completes
    wr_valid = 1; wr_addr = 4'd1; wr_data = 8'h0F; wr_mask = 8'hFF;
    tick();
    wr_addr = 4'd2; wr_data = 8'hF0;
    tick(2);
    chk_ana("b2b first drv", 1, 8'h0F, 8'hF0);
    tick(4);
    chk_ctl("b2b first done", 1, 1, 0, 0);
    tick();                                     // second accepted in done cycle
    wr_valid = 0;
    chk_ctl("b2b second pre", 0, 0, 0, 1);
    chk_ana("b2b second pre", -1, 8'hFF, 8'hFF);
    tick(2);
    chk_ana("b2b second drv", 2, 8'hF0, 8'h0F);
    tick(4);
    chk_b("b2b second done", 32'(wr_done), 1);
    tick();

    // Reset during DRIVE of addr 3
    wr_valid = 1; wr_addr = 4'd3; wr_data = 8'h55; wr_mask = 8'hFF;
    tick();
    wr_valid = 0;
    tick(2);
    chk_ana("rst drv", 3, 8'h55, 8'hAA);
    rst = 1;
    tick();
    rst = 0;
    chk_ctl("rst abort", 1, 0, 0, 0);
    chk_ana("rst abort", -1, 8'hFF, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_b($sformatf("rst no done %0d", i), 32'(wr_done), 0);
    end

    // Sense-amp round trip: addr 2, data 3C
    wr_valid = 1; wr_addr = 4'd2; wr_data = 8'h3C; wr_mask = 8'hFF;
    tick();
    wr_valid = 0;
    tick(2);
    chk_r("sa row sel", row_wr[2], 1.5);
    for (int c = 0; c < 8; c++) sa[c] = (bl_wr[c] > blb_wr[c]) ? 1.5 : 0.0;
    for (int c = 0; c < 8; c++)
      chk_r($sformatf("sa out[%0d]", c), sa[c], (c >= 2 && c <= 5) ? 1.5 : 0.0);
    tick(4);
    chk_b("sa done", 32'(wr_done), 1);

    // ROWS=12: addr 13 rejected
    v2 = 1; a2 = 4'd13; d2 = 8'hFF; m2 = 8'hFF;
    tick();
    v2 = 0;
    chk_b("oob err", 32'(err2), 1);
    chk_b("oob busy", 32'(busy2), 0);
    chk_b("oob ready", 32'(rdy2), 1);
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 12; r++)
        chk_r($sformatf("oob row2[%0d] t%0d", r, i), row2[r], 0.0);
      if (i > 0) chk_b($sformatf("oob err clear t%0d", i), 32'(err2), 0);
      chk_b($sformatf("oob busy t%0d", i), 32'(busy2), 0);
      tick();
    end

    // ROWS=12: addr 11 completes normally
    v2 = 1; a2 = 4'd11; d2 = 8'h81; m2 = 8'hFF;
    tick();
    v2 = 0;
    chk_b("r12 busy", 32'(busy2), 1);
    tick(2);
    chk_r("r12 row11", row2[11], 1.5);
    chk_r("r12 row10", row2[10], 0.0);
    chk_r("r12 bl0", bl2[0], 1.5);
    chk_r("r12 blb0", blb2[0], 0.0);
    chk_r("r12 bl1", bl2[1], 0.0);
    chk_r("r12 blb1", blb2[1], 1.5);
    tick(4);
    chk_b("r12 done", 32'(done2), 1);
    chk_b("r12 err", 32'(err2), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
